// File: rtl/parport_ctrl.sv
// Centronics-style printer port transmit controller.
// Queues bytes from the core in a small FIFO and sequences each one onto
// the parallel port as data setup, an active-low strobe pulse and hold,
// waiting for the printer busy line to drop before starting each byte.
module parport_ctrl #(
  parameter int FIFO_DEPTH  = 16,
  parameter int SETUP_CYC   = 32,
  parameter int STROBE_CYC  = 32,
  parameter int HOLD_CYC    = 32,
  parameter int TIMEOUT_CYC = 3200000
) (
  input  logic                          clk32,
  input  logic                          reset_n,
  input  logic                          enable,
  input  logic [7:0]                    wr_data,
  input  logic                          wr_stb,
  input  logic                          flush,
  input  logic                          clr_err,
  input  logic                          pp_busy,
  output logic [7:0]                    pp_data_out,
  output logic                          pp_data_oe,
  output logic                          pp_strobe_out,
  output logic                          pp_strobe_oe,
  output logic                          fifo_full,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          busy_sync,
  output logic                          tx_idle,
  output logic                          tx_done,
  output logic                          timeout,
  output logic                          overflow
);

  localparam int PW   = $clog2(FIFO_DEPTH);
  localparam int LW   = PW + 1;
  localparam int MAXC = (SETUP_CYC > STROBE_CYC)
                        ? ((SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC)
                        : ((STROBE_CYC > HOLD_CYC) ? STROBE_CYC : HOLD_CYC);
  localparam int CW   = $clog2(MAXC + 1);

  localparam logic [LW-1:0] DEPTH_L   = LW'(FIFO_DEPTH);
  localparam logic [CW-1:0] SETUP_LD  = CW'(SETUP_CYC - 1);
  localparam logic [CW-1:0] STROBE_LD = CW'(STROBE_CYC - 1);
  localparam logic [CW-1:0] HOLD_LD   = CW'(HOLD_CYC - 1);
  localparam logic [31:0]   TO_LAST   = 32'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

  state_t          state_q;
  logic [CW-1:0]   cnt_q;
  logic [7:0]      data_q;
  logic            strobe_q;
  logic            done_q;
  logic            busyMeta_q;
  logic            busySync_q;
  logic            dataOe_q;
  logic            strobeOe_q;
  logic [31:0]     tcnt_q;
  logic            timeout_q;
  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [PW-1:0]   wrPtr_q, wrPtr_d;
  logic [PW-1:0]   rdPtr_q, rdPtr_d;
  logic [LW-1:0]   count_q, count_d;
  logic            overflow_q, overflow_d;

  logic            fifoEmpty;
  logic            fifoFullInt;
  logic            wrAccept;
  logic            ovfSet;
  logic            popEn;
  logic            stallEn;
  logic            timeoutSet;
  logic [7:0]      headByte;

  assign fifoEmpty   = (count_q == '0);
  assign fifoFullInt = (count_q == DEPTH_L);
  assign wrAccept    = wr_stb && !fifoFullInt && !flush;
  assign ovfSet      = wr_stb && fifoFullInt && !flush;
  assign popEn       = (state_q == IDLE) && enable && !fifoEmpty && !busySync_q;
  assign stallEn     = (state_q == IDLE) && enable && !fifoEmpty && busySync_q;
  assign timeoutSet  = stallEn && (tcnt_q == TO_LAST);
  assign headByte    = mem_q[rdPtr_q];

  // Two-flop synchroniser for the printer busy line; resets to busy.
  always_ff @(posedge clk32 or negedge reset_n) begin
    if (!reset_n) begin
      busyMeta_q <= 1'b1;
      busySync_q <= 1'b1;
    end else begin
      busyMeta_q <= pp_busy;
      busySync_q <= busyMeta_q;
    end
  end

  // Pad output enables follow enable one cycle later.
  always_ff @(posedge clk32 or negedge reset_n) begin
    if (!reset_n) begin
      dataOe_q   <= 1'b0;
      strobeOe_q <= 1'b0;
    end else begin
      dataOe_q   <= enable;
      strobeOe_q <= enable;
    end
  end

  // FIFO bookkeeping: fullness is judged before any pop, flush beats writes.
  always_comb begin
    wrPtr_d    = wrPtr_q;
    rdPtr_d    = rdPtr_q;
    count_d    = count_q;
    overflow_d = ovfSet ? 1'b1 : (clr_err ? 1'b0 : overflow_q);
    if (flush) begin
      wrPtr_d = '0;
      rdPtr_d = '0;
      count_d = '0;
    end else begin
      if (wrAccept) wrPtr_d = wrPtr_q + PW'(1);
      if (popEn)    rdPtr_d = rdPtr_q + PW'(1);
      case ({wrAccept, popEn})
        2'b10:   count_d = count_q + LW'(1);
        2'b01:   count_d = count_q - LW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // FIFO pointer, count and overflow registers.
  always_ff @(posedge clk32 or negedge reset_n) begin
    if (!reset_n) begin
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wrPtr_q    <= wrPtr_d;
      rdPtr_q    <= rdPtr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // FIFO storage; contents are meaningless once the count is cleared.
  always_ff @(posedge clk32) begin
    if (wrAccept) mem_q[wrPtr_q] <= wr_data;
  end

  // Transfer sequencer: load byte, setup, strobe low, hold, done pulse.
  always_ff @(posedge clk32 or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      data_q   <= 8'h00;
      strobe_q <= 1'b1;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (popEn) begin
            data_q  <= headByte;
            cnt_q   <= SETUP_LD;
            state_q <= SETUP;
          end
        end
        SETUP: begin
          if (cnt_q == '0) begin
            strobe_q <= 1'b0;
            cnt_q    <= STROBE_LD;
            state_q  <= STROBE;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        STROBE: begin
          if (cnt_q == '0) begin
            strobe_q <= 1'b1;
            cnt_q    <= HOLD_LD;
            state_q  <= HOLD;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        HOLD: begin
          if (cnt_q == '0) begin
            done_q  <= 1'b1;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Busy-stall watchdog: counts while a byte waits on busy, saturates, sticky flag.
  always_ff @(posedge clk32 or negedge reset_n) begin
    if (!reset_n) begin
      tcnt_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (!stallEn) begin
        tcnt_q <= '0;
      end else if (tcnt_q != TO_LAST) begin
        tcnt_q <= tcnt_q + 32'd1;
      end
      timeout_q <= timeoutSet ? 1'b1 : (clr_err ? 1'b0 : timeout_q);
    end
  end

  assign pp_data_out   = data_q;
  assign pp_data_oe    = dataOe_q;
  assign pp_strobe_out = strobe_q;
  assign pp_strobe_oe  = strobeOe_q;
  assign fifo_full     = fifoFullInt;
  assign fifo_level    = count_q;
  assign busy_sync     = busySync_q;
  assign tx_idle       = (state_q == IDLE) && fifoEmpty;
  assign tx_done       = done_q;
  assign timeout       = timeout_q;
  assign overflow      = overflow_q;

endmodule
